bp_fetch_ctrl: RTL and testbench

- Fetch-stage next-PC controller directly upstream of the branch target buffer.
- Owns the fetch PC register and drives the BTB read index from that PC.
- Compares the returned tag and valid bit to make an always-taken prediction on a hit.
- Carries prediction metadata through IF->ID->EX, checks it against the EX resolution, then issues the redirect/flush and the BTB update write.

---
 rtl/bp_fetch_ctrl.sv | 153 +++++++++++++++
 tb/tb_bp_fetch_ctrl.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/bp_fetch_ctrl.sv
// Fetch-stage next-PC controller. It owns the fetch PC, predicts from the BTB,
// carries prediction metadata IF->ID->EX and resolves mispredicts and BTB updates.
module bp_fetch_ctrl #(
   parameter int unsigned INDEX_WIDTH = 12,
   parameter logic [31:0] RESET_PC    = 32'h0000_0000,
   localparam int unsigned TW         = 30 - INDEX_WIDTH
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  logic                   stall_i,
   output logic [31:0]            pc_o,
   output logic [INDEX_WIDTH-1:0] btb_rd_index_o,
   input  logic                   btb_valid_i,
   input  logic [TW-1:0]          btb_tag_i,
   input  logic [31:0]            btb_target_i,
   output logic                   btb_wren_o,
   output logic [INDEX_WIDTH-1:0] btb_wr_index_o,
   output logic [TW-1:0]          btb_wr_tag_o,
   output logic [31:0]            btb_wr_target_o,
   input  logic                   ex_is_ctrl_i,
   input  logic                   ex_taken_i,
   input  logic [31:0]            ex_target_i,
   output logic [31:0]            ex_pc_o,
   output logic                   flush_o,
   output logic [31:0]            mispredict_cnt_o,
   output logic [31:0]            ctrl_cnt_o
);

   logic [31:0]            pc_q;
   logic                   id_valid_q, id_pred_taken_q;
   logic [31:0]            id_pc_q, id_pred_target_q;
   logic                   ex_valid_q, ex_pred_taken_q;
   logic [31:0]            ex_pc_q, ex_pred_target_q;
   logic                   wren_q;
   logic [INDEX_WIDTH-1:0] wr_index_q;
   logic [TW-1:0]          wr_tag_q;
   logic [31:0]            wr_target_q;
   logic [31:0]            mis_cnt_q, ctrl_cnt_q;

   logic        hit;
   logic [31:0] if_pred_target;
   logic        ex_fire, ctrl_taken, pred_matches;
   logic        mispredict_raw, need_write;
   logic [31:0] redirect_pc;
   logic        flush, wr_now, ctrl_fire;

   assign hit            = btb_valid_i && (btb_tag_i == pc_q[31:INDEX_WIDTH+2]);
   assign if_pred_target = hit ? btb_target_i : pc_q + 32'd4;

   assign ex_fire      = ex_valid_q && !stall_i;
   assign ctrl_taken   = ex_is_ctrl_i && ex_taken_i;
   assign pred_matches = ex_pred_taken_q && (ex_pred_target_q == ex_target_i);

   // Only a taken branch that was missed or mistargeted earns a BTB entry;
   // every other mispredict just falls through to ex_pc+4.
   always_comb begin
      mispredict_raw = 1'b0;
      need_write     = 1'b0;
      redirect_pc    = ex_pc_q + 32'd4;
      if (ctrl_taken) begin
         if (!pred_matches) begin
            mispredict_raw = 1'b1;
            need_write     = 1'b1;
            redirect_pc    = ex_target_i;
         end
      end else if (ex_pred_taken_q) begin
         mispredict_raw = 1'b1;
      end
   end

   assign flush     = ex_fire && mispredict_raw;
   assign wr_now    = flush && need_write;
   assign ctrl_fire = ex_fire && ex_is_ctrl_i;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         pc_q             <= RESET_PC;
         id_valid_q       <= 1'b0;
         id_pred_taken_q  <= 1'b0;
         id_pc_q          <= 32'd0;
         id_pred_target_q <= 32'd0;
         ex_valid_q       <= 1'b0;
         ex_pred_taken_q  <= 1'b0;
         ex_pc_q          <= 32'd0;
         ex_pred_target_q <= 32'd0;
      end else if (!stall_i) begin
         if (flush) begin
            pc_q             <= redirect_pc;
            id_valid_q       <= 1'b0;
            id_pred_taken_q  <= 1'b0;
            id_pc_q          <= 32'd0;
            id_pred_target_q <= 32'd0;
            ex_valid_q       <= 1'b0;
            ex_pred_taken_q  <= 1'b0;
            ex_pc_q          <= 32'd0;
            ex_pred_target_q <= 32'd0;
         end else begin
            pc_q             <= if_pred_target;
            id_valid_q       <= 1'b1;
            id_pred_taken_q  <= hit;
            id_pc_q          <= pc_q;
            id_pred_target_q <= if_pred_target;
            ex_valid_q       <= id_valid_q;
            ex_pred_taken_q  <= id_pred_taken_q;
            ex_pc_q          <= id_pc_q;
            ex_pred_target_q <= id_pred_target_q;
         end
      end
   end

   // The write pulse is not frozen by stall: it retires one cycle after resolution.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wren_q      <= 1'b0;
         wr_index_q  <= '0;
         wr_tag_q    <= '0;
         wr_target_q <= 32'd0;
      end else begin
         wren_q <= wr_now;
         if (wr_now) begin
            wr_index_q  <= ex_pc_q[INDEX_WIDTH+1:2];
            wr_tag_q    <= ex_pc_q[31:INDEX_WIDTH+2];
            wr_target_q <= ex_target_i;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         mis_cnt_q  <= 32'd0;
         ctrl_cnt_q <= 32'd0;
      end else begin
         if (flush && (mis_cnt_q != 32'hFFFF_FFFF)) begin
            mis_cnt_q <= mis_cnt_q + 32'd1;
         end
         if (ctrl_fire && (ctrl_cnt_q != 32'hFFFF_FFFF)) begin
            ctrl_cnt_q <= ctrl_cnt_q + 32'd1;
         end
      end
   end

   assign pc_o             = pc_q;
   assign btb_rd_index_o   = pc_q[INDEX_WIDTH+1:2];
   assign btb_wren_o       = wren_q;
   assign btb_wr_index_o   = wr_index_q;
   assign btb_wr_tag_o     = wr_tag_q;
   assign btb_wr_target_o  = wr_target_q;
   assign ex_pc_o          = ex_pc_q;
   assign flush_o          = flush;
   assign mispredict_cnt_o = mis_cnt_q;
   assign ctrl_cnt_o       = ctrl_cnt_q;

endmodule

// File: tb/tb_bp_fetch_ctrl.sv
// Directed bench for bp_fetch_ctrl: a per-cycle vector table plus a hand-written
// reset-during-write-pulse sequence. Outputs are checked #1 after the falling edge.
module tb_bp_fetch_ctrl;

   localparam int unsigned IW = 12;
   localparam int unsigned TW = 30 - IW;

   logic          clk_i = 1'b0;
   logic          rst_i, stall_i;
   logic [31:0]   pc_o;
   logic [IW-1:0] btb_rd_index_o;
   logic          btb_valid_i;
   logic [TW-1:0] btb_tag_i;
   logic [31:0]   btb_target_i;
   logic          btb_wren_o;
   logic [IW-1:0] btb_wr_index_o;
   logic [TW-1:0] btb_wr_tag_o;
   logic [31:0]   btb_wr_target_o;
   logic          ex_is_ctrl_i, ex_taken_i;
   logic [31:0]   ex_target_i, ex_pc_o;
   logic          flush_o;
   logic [31:0]   mispredict_cnt_o, ctrl_cnt_o;

   always #5 clk_i = ~clk_i;

   bp_fetch_ctrl #(.INDEX_WIDTH(IW), .RESET_PC(32'h0000_0100)) dut (
      .clk_i(clk_i), .rst_i(rst_i), .stall_i(stall_i),
      .pc_o(pc_o), .btb_rd_index_o(btb_rd_index_o),
      .btb_valid_i(btb_valid_i), .btb_tag_i(btb_tag_i), .btb_target_i(btb_target_i),
      .btb_wren_o(btb_wren_o), .btb_wr_index_o(btb_wr_index_o),
      .btb_wr_tag_o(btb_wr_tag_o), .btb_wr_target_o(btb_wr_target_o),
      .ex_is_ctrl_i(ex_is_ctrl_i), .ex_taken_i(ex_taken_i), .ex_target_i(ex_target_i),
      .ex_pc_o(ex_pc_o), .flush_o(flush_o),
      .mispredict_cnt_o(mispredict_cnt_o), .ctrl_cnt_o(ctrl_cnt_o)
   );

   typedef struct {
      logic          rst, stall, bv;
      logic [TW-1:0] btag;
      logic [31:0]   btgt;
      logic          ctrl, taken;
      logic [31:0]   extgt;
      logic [31:0]   pc;
      logic          flush, wren;
      logic [31:0]   expc, mcnt, ccnt;
      logic [IW-1:0] widx;
      logic [TW-1:0] wtag;
      logic [31:0]   wtgt;
   } vec_t;

   vec_t vecs[$];
   int   n_tests = 0;
   int   n_fail  = 0;

   function automatic vec_t row(logic rst, logic stall, logic bv, logic [TW-1:0] btag,
                                logic [31:0] btgt, logic ctrl, logic taken, logic [31:0] extgt,
                                logic [31:0] pc, logic flush, logic wren, logic [31:0] expc,
                                logic [31:0] mcnt, logic [31:0] ccnt, logic [IW-1:0] widx,
                                logic [TW-1:0] wtag, logic [31:0] wtgt);
      vec_t v;
      v.rst = rst; v.stall = stall; v.bv = bv; v.btag = btag; v.btgt = btgt;
      v.ctrl = ctrl; v.taken = taken; v.extgt = extgt;
      v.pc = pc; v.flush = flush; v.wren = wren; v.expc = expc;
      v.mcnt = mcnt; v.ccnt = ccnt; v.widx = widx; v.wtag = wtag; v.wtgt = wtgt;
      return v;
   endfunction

   task automatic chk(input string name, input int r, input logic [31:0] got,
                      input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL row %0d %s: got %h expected %h", r, name, got, exp);
      end
   endtask

   task automatic drive(input logic rst, input logic stall, input logic bv,
                        input logic [TW-1:0] btag, input logic [31:0] btgt, input logic ctrl,
                        input logic taken, input logic [31:0] extgt);
      rst_i = rst; stall_i = stall; btb_valid_i = bv; btb_tag_i = btag;
      btb_target_i = btgt; ex_is_ctrl_i = ctrl; ex_taken_i = taken; ex_target_i = extgt;
   endtask

   task automatic apply(input int r, input vec_t v);
      logic [31:0] epc;
      @(negedge clk_i);
      drive(v.rst, v.stall, v.bv, v.btag, v.btgt, v.ctrl, v.taken, v.extgt);
      #1;
      epc = v.pc;
      chk("pc_o", r, pc_o, v.pc);
      chk("btb_rd_index_o", r, 32'(btb_rd_index_o), 32'(epc[IW+1:2]));
      chk("flush_o", r, 32'(flush_o), 32'(v.flush));
      chk("btb_wren_o", r, 32'(btb_wren_o), 32'(v.wren));
      chk("ex_pc_o", r, ex_pc_o, v.expc);
      chk("mispredict_cnt_o", r, mispredict_cnt_o, v.mcnt);
      chk("ctrl_cnt_o", r, ctrl_cnt_o, v.ccnt);
      chk("btb_wr_index_o", r, 32'(btb_wr_index_o), 32'(v.widx));
      chk("btb_wr_tag_o", r, 32'(btb_wr_tag_o), 32'(v.wtag));
      chk("btb_wr_target_o", r, btb_wr_target_o, v.wtgt);
   endtask

   initial begin
      // reset, BTB empty, straight-line fetch from 0x100
      vecs.push_back(row(0,0,0,0,0, 0,0,0, 32'h100,0,0,0,        0,0, 0,0,0));
      vecs.push_back(row(0,0,0,0,0, 0,0,0, 32'h104,0,0,0,        0,0, 0,0,0));
      vecs.push_back(row(0,0,0,0,0, 0,0,0, 32'h108,0,0,32'h100,  0,0, 0,0,0));
      vecs.push_back(row(0,0,0,0,0, 0,0,0, 32'h10C,0,0,32'h104,  0,0, 0,0,0));
      // taken branch at 0x108 missed by the BTB -> redirect to 0x200
      vecs.push_back(row(0,0,0,0,0, 1,1,32'h200, 32'h110,1,0,32'h108, 0,0, 0,0,0));
      // BTB hit at 0x200 predicts 0x400, later resolved correctly
      vecs.push_back(row(0,0,1,0,32'h400, 0,0,0, 32'h200,0,1,0,       1,1, 12'h042,0,32'h200));
      vecs.push_back(row(0,0,0,0,0, 0,0,0,            32'h400,0,0,0,       1,1, 12'h042,0,32'h200));
      vecs.push_back(row(0,0,0,0,0, 1,1,32'h400,      32'h404,0,0,32'h200, 1,1, 12'h042,0,32'h200));
      vecs.push_back(row(0,0,0,0,0, 0,0,0,            32'h408,0,0,32'h400, 1,2, 12'h042,0,32'h200));
      // hit at 0x40C to 0x300, then branch at 0x300 resolves taken to 0x500
      vecs.push_back(row(0,0,1,0,32'h300, 0,0,0,      32'h40C,0,0,32'h404, 1,2, 12'h042,0,32'h200));
      vecs.push_back(row(0,0,0,0,0, 0,0,0,            32'h300,0,0,32'h408, 1,2, 12'h042,0,32'h200));
      vecs.push_back(row(0,0,0,0,0, 1,1,32'h300,      32'h304,0,0,32'h40C, 1,2, 12'h042,0,32'h200));
      vecs.push_back(row(0,0,0,0,0, 1,1,32'h500,      32'h308,1,0,32'h300, 1,3, 12'h042,0,32'h200));
      vecs.push_back(row(0,0,0,0,0, 0,0,0,            32'h500,0,1,0,       2,4, 12'h0C0,0,32'h500));
      // hit 0x504->0x200, hit 0x200->0x400, 0x200 resolves not taken
      vecs.push_back(row(0,0,1,0,32'h200, 0,0,0,      32'h504,0,0,0,       2,4, 12'h0C0,0,32'h500));
      vecs.push_back(row(0,0,1,0,32'h400, 0,0,0,      32'h200,0,0,32'h500, 2,4, 12'h0C0,0,32'h500));
      vecs.push_back(row(0,0,0,0,0, 1,1,32'h200,      32'h400,0,0,32'h504, 2,4, 12'h0C0,0,32'h500));
      vecs.push_back(row(0,0,0,0,0, 1,0,0,            32'h404,1,0,32'h200, 2,5, 12'h0C0,0,32'h500));
      vecs.push_back(row(0,0,0,0,0, 0,0,0,            32'h204,0,0,0,       3,6, 12'h0C0,0,32'h500));
      vecs.push_back(row(0,0,0,0,0, 0,0,0,            32'h208,0,0,0,       3,6, 12'h0C0,0,32'h500));
      // mispredict sitting in EX under a 3-cycle stall
      vecs.push_back(row(0,1,0,0,0, 1,1,32'h600,      32'h20C,0,0,32'h204, 3,6, 12'h0C0,0,32'h500));
      vecs.push_back(row(0,1,0,0,0, 1,1,32'h600,      32'h20C,0,0,32'h204, 3,6, 12'h0C0,0,32'h500));
      vecs.push_back(row(0,1,0,0,0, 1,1,32'h600,      32'h20C,0,0,32'h204, 3,6, 12'h0C0,0,32'h500));
      vecs.push_back(row(0,0,0,0,0, 1,1,32'h600,      32'h20C,1,0,32'h204, 3,6, 12'h0C0,0,32'h500));
      // write pulse retires under stall, PC held
      vecs.push_back(row(0,1,0,0,0, 0,0,0,            32'h600,0,1,0,       4,7, 12'h081,0,32'h600));
      vecs.push_back(row(0,1,0,0,0, 0,0,0,            32'h600,0,0,0,       4,7, 12'h081,0,32'h600));
      vecs.push_back(row(0,0,0,0,0, 0,0,0,            32'h600,0,0,0,       4,7, 12'h081,0,32'h600));
      vecs.push_back(row(0,0,0,0,0, 0,0,0,            32'h604,0,0,0,       4,7, 12'h081,0,32'h600));
      // reset in the same cycle as a flush discards redirect and write
      vecs.push_back(row(1,0,0,0,0, 1,1,32'h700,      32'h608,1,0,32'h600, 4,7, 12'h081,0,32'h600));
      vecs.push_back(row(0,0,1,0,32'hFFFF_FFFC, 0,0,0, 32'h100,0,0,0,      0,0, 0,0,0));
      // wrap from 0xFFFF_FFFC, then non-ctrl alias at 0x100 mispredicts
      vecs.push_back(row(0,0,0,0,0, 0,0,0,   32'hFFFF_FFFC,0,0,0,          0,0, 0,0,0));
      vecs.push_back(row(0,0,0,0,0, 0,0,0,   32'h0,1,0,32'h100,            0,0, 0,0,0));
      vecs.push_back(row(0,0,0,0,0, 0,0,0,   32'h104,0,0,0,                1,0, 0,0,0));
      vecs.push_back(row(0,0,0,0,0, 0,0,0,   32'h108,0,0,0,                1,0, 0,0,0));
      vecs.push_back(row(0,0,0,0,0, 1,1,32'hABCD_0010, 32'h10C,1,0,32'h104, 1,0, 0,0,0));
      vecs.push_back(row(0,0,0,0,0, 0,0,0, 32'hABCD_0010,0,1,0,        2,1, 12'h041,0,32'hABCD_0010));
      vecs.push_back(row(0,0,0,0,0, 0,0,0, 32'hABCD_0014,0,0,0,        2,1, 12'h041,0,32'hABCD_0010));
      vecs.push_back(row(0,0,0,0,0, 1,1,32'h40, 32'hABCD_0018,1,0,32'hABCD_0010, 2,1, 12'h041,0,32'hABCD_0010));
      // non-zero write tag; valid entry with wrong tag is a miss
      vecs.push_back(row(0,0,1,18'h1,32'h999, 0,0,0, 32'h40,0,1,0,     3,2, 12'h004,18'h2AF34,32'h40));
      vecs.push_back(row(0,0,0,0,0, 0,0,0,            32'h44,0,0,0,     3,2, 12'h004,18'h2AF34,32'h40));

      drive(1, 0, 0, '0, 32'd0, 0, 0, 32'd0);
      repeat (2) @(posedge clk_i);
      foreach (vecs[i]) apply(i, vecs[i]);

      // reset during the write pulse cancels it
      @(negedge clk_i);
      drive(0, 0, 0, '0, 32'd0, 1, 1, 32'h80);
      #1 chk("seq_flush", 100, 32'(flush_o), 32'd1);
      chk("seq_ex_pc", 100, ex_pc_o, 32'h40);
      @(negedge clk_i);
      drive(1, 0, 0, '0, 32'd0, 0, 0, 32'd0);
      #1 chk("seq_wren_pending", 101, 32'(btb_wren_o), 32'd1);
      chk("seq_pc_redirect", 101, pc_o, 32'h80);
      @(negedge clk_i);
      drive(0, 0, 0, '0, 32'd0, 0, 0, 32'd0);
      #1 chk("seq_wren_after_rst", 102, 32'(btb_wren_o), 32'd0);
      chk("seq_pc_after_rst", 102, pc_o, 32'h100);
      chk("seq_mcnt_after_rst", 102, mispredict_cnt_o, 32'd0);
      chk("seq_ccnt_after_rst", 102, ctrl_cnt_o, 32'd0);
      chk("seq_wr_target_after_rst", 102, btb_wr_target_o, 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
